// File: rtl/hero_write_rx_if.sv
// Hero write bus plus the downstream beat stream and status of hero_write_rx.
// HERO_WRITE_RX_STATS_EN adds the txn_cnt/drop_cnt statistics signals.
interface hero_write_rx_if #(
    parameter int HERO_WIDTH = 36
);
    logic [1:0]            hero_cycle_type;
    logic [HERO_WIDTH-1:0] hero_wdat;
    logic                  hero_clk_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [HERO_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  drop_pulse;
    logic                  busy;
`ifdef HERO_WRITE_RX_STATS_EN
    logic [15:0]           txn_cnt;
    logic [15:0]           drop_cnt;

    modport master (
        output hero_cycle_type, hero_wdat, hero_clk_en, out_ready,
        input  out_valid, out_data, out_last, drop_pulse, busy, txn_cnt, drop_cnt
    );
    modport slave (
        input  hero_cycle_type, hero_wdat, hero_clk_en, out_ready,
        output out_valid, out_data, out_last, drop_pulse, busy, txn_cnt, drop_cnt
    );
`else
    modport master (
        output hero_cycle_type, hero_wdat, hero_clk_en, out_ready,
        input  out_valid, out_data, out_last, drop_pulse, busy
    );
    modport slave (
        input  hero_cycle_type, hero_wdat, hero_clk_en, out_ready,
        output out_valid, out_data, out_last, drop_pulse, busy
    );
`endif
endinterface

// File: rtl/hero_write_rx.sv
// Store-and-forward receiver for the hero write bus: only complete transactions are released.
// Optional macro HERO_WRITE_RX_STATS_EN adds saturating txn_cnt/drop_cnt counters.
module hero_write_rx #(
    parameter int HERO_WIDTH = 36,
    parameter int DEPTH      = 16,
    parameter int MAX_BEATS  = 8
) (
    input  logic          clk,
    input  logic          rst,
    hero_write_rx_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DROP} state_t;

    state_t              r_state;
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_commit_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_beat_cnt;
    logic                r_drop_pulse;
    logic [HERO_WIDTH:0] r_mem [DEPTH];

    logic                w_is_valid;
    logic                w_is_done;
    logic                w_is_ill;
    logic                w_beat;
    logic [PW-1:0]       w_free;
    logic                w_drop;
    logic                w_wr_en;
    logic                w_out_valid;
    logic                w_rd_fire;
    logic [HERO_WIDTH:0] w_rd_entry;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        w_is_valid  = bus.hero_clk_en && (bus.hero_cycle_type == 2'd1);
        w_is_done   = bus.hero_clk_en && (bus.hero_cycle_type == 2'd2);
        w_is_ill    = bus.hero_clk_en && (bus.hero_cycle_type == 2'd3);
        w_beat      = w_is_valid || w_is_done;
        w_free      = PW'(DEPTH) - (r_wr_ptr - r_rd_ptr);
        // DROP swallows everything; a second illegal cycle there must not pulse again
        w_drop      = (r_state != S_DROP) &&
                      (w_is_ill || (w_beat && ((w_free == '0) ||
                       (r_state == S_ACTIVE && r_beat_cnt == CW'(MAX_BEATS)))));
        w_wr_en     = (r_state != S_DROP) && w_beat && !w_drop;
        w_out_valid = (r_rd_ptr != r_commit_ptr);
        w_rd_fire   = w_out_valid && bus.out_ready;
        w_rd_entry  = r_mem[r_rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_is_done, bus.hero_wdat};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_beat_cnt   <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_drop_pulse <= 1'b0;
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_drop) begin
                r_wr_ptr     <= r_commit_ptr;
                r_drop_pulse <= 1'b1;
                r_beat_cnt   <= '0;
                r_state      <= w_is_done ? S_IDLE : S_DROP;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_is_done) begin
                    r_commit_ptr <= r_wr_ptr + PW'(1);
                    r_beat_cnt   <= '0;
                    r_state      <= S_IDLE;
                end else begin
                    r_beat_cnt <= r_beat_cnt + CW'(1);
                    r_state    <= S_ACTIVE;
                end
            end else if (r_state == S_DROP && w_is_done) begin
                r_state <= S_IDLE;
            end
        end
    end

    // Buffer contents are never reset, so the read port is masked when empty
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = w_out_valid ? w_rd_entry[HERO_WIDTH-1:0] : '0;
    assign bus.out_last   = w_out_valid && w_rd_entry[HERO_WIDTH];
    assign bus.drop_pulse = r_drop_pulse;
    assign bus.busy       = (r_state != S_IDLE);

`ifdef HERO_WRITE_RX_STATS_EN
    logic [15:0] r_txn_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_txn_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_wr_en && w_is_done) begin
                r_txn_cnt <= sat_inc(r_txn_cnt);
            end
            if (w_drop) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    assign bus.txn_cnt  = r_txn_cnt;
    assign bus.drop_cnt = r_drop_cnt;
`endif
endmodule
